// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel clock-enable divider, IDLE/RUN/STOPPING control, registered sync/blank/de/strobes.
// All outputs are registered and aligned with h_count/v_count; stopping completes the current frame before idling.
module vga_timing_gen #(
   parameter int   CE_DIV   = 4,
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0,
   parameter int   CNT_W    = 11
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   output logic             pixel_ce,
   output logic             hsync,
   output logic             vsync,
   output logic             hblank,
   output logic             vblank,
   output logic             de,
   output logic [CNT_W-1:0] h_count,
   output logic [CNT_W-1:0] v_count,
   output logic             line_start,
   output logic             frame_start,
   output logic             running
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);
   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   // One extra bit so sync-end bounds equal to the total still fit.
   localparam logic [CNT_W:0]   H_ACT    = (CNT_W+1)'(H_ACTIVE);
   localparam logic [CNT_W:0]   HS_BEG   = (CNT_W+1)'(H_ACTIVE + H_FP);
   localparam logic [CNT_W:0]   HS_END   = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W:0]   V_ACT    = (CNT_W+1)'(V_ACTIVE);
   localparam logic [CNT_W:0]   VS_BEG   = (CNT_W+1)'(V_ACTIVE + V_FP);
   localparam logic [CNT_W:0]   VS_END   = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

   generate
      if (CE_DIV < 1 || H_TOTAL - 1 >= (1 << CNT_W) || V_TOTAL - 1 >= (1 << CNT_W)) begin : g_bad_cfg
         $error("vga_timing_gen: CE_DIV must be >= 1 and CNT_W must hold H_TOTAL-1 and V_TOTAL-1");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOPPING} state_t;

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic               pce_q, pce_d;
   logic [CNT_W-1:0]   h_q, h_d, v_q, v_d, h_nxt, v_nxt;
   logic               hsync_q, hsync_d, vsync_q, vsync_d;
   logic               hblank_q, hblank_d, vblank_q, vblank_d, de_q, de_d;
   logic               ls_q, ls_d, fs_q, fs_d, run_q, run_d;
   logic               act;
   logic [CNT_W:0]     hx, vx;

   always_comb begin
      div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      pce_d    = (div_d == DIV_LAST);
      state_d  = state_q;
      h_d      = h_q;
      v_d      = v_q;
      ls_d     = 1'b0;
      fs_d     = 1'b0;
      h_nxt    = (h_q == H_LAST) ? '0 : h_q + 1'b1;
      v_nxt    = (h_q != H_LAST) ? v_q : ((v_q == V_LAST) ? '0 : v_q + 1'b1);

      if (pce_q) begin
         case (state_q)
            S_IDLE: begin
               if (enable) begin
                  state_d = S_RUN;
                  h_d     = '0;
                  v_d     = '0;
                  ls_d    = 1'b1;
                  fs_d    = 1'b1;
               end
            end
            default: begin
               // Enable low on the final pixel of a frame idles immediately, from RUN or STOPPING.
               if (!enable && h_q == H_LAST && v_q == V_LAST) begin
                  state_d = S_IDLE;
                  h_d     = '0;
                  v_d     = '0;
               end else begin
                  state_d = enable ? S_RUN : S_STOPPING;
                  h_d     = h_nxt;
                  v_d     = v_nxt;
                  ls_d    = (h_nxt == '0);
                  fs_d    = (h_nxt == '0) && (v_nxt == '0);
               end
            end
         endcase
      end

      act      = (state_d != S_IDLE);
      hx       = {1'b0, h_d};
      vx       = {1'b0, v_d};
      hsync_d  = (act && hx >= HS_BEG && hx < HS_END) ? HS_POL : ~HS_POL;
      vsync_d  = (act && vx >= VS_BEG && vx < VS_END) ? VS_POL : ~VS_POL;
      hblank_d = !act || (hx >= H_ACT);
      vblank_d = !act || (vx >= V_ACT);
      de_d     = !hblank_d && !vblank_d;
      run_d    = act;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         div_q    <= '0;
         pce_q    <= 1'b0;
         h_q      <= '0;
         v_q      <= '0;
         hsync_q  <= ~HS_POL;
         vsync_q  <= ~VS_POL;
         hblank_q <= 1'b1;
         vblank_q <= 1'b1;
         de_q     <= 1'b0;
         ls_q     <= 1'b0;
         fs_q     <= 1'b0;
         run_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         pce_q    <= pce_d;
         h_q      <= h_d;
         v_q      <= v_d;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
         hblank_q <= hblank_d;
         vblank_q <= vblank_d;
         de_q     <= de_d;
         ls_q     <= ls_d;
         fs_q     <= fs_d;
         run_q    <= run_d;
      end
   end

   assign pixel_ce    = pce_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign hblank      = hblank_q;
   assign vblank      = vblank_q;
   assign de          = de_q;
   assign h_count     = h_q;
   assign v_count     = v_q;
   assign line_start  = ls_q;
   assign frame_start = fs_q;
   assign running     = run_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: per-clock expected outputs from a pixel-index frame model are queued and checked by a separate monitor.
module tb_vga_timing_gen;
   localparam int   CE    = 3;
   localparam int   HA = 4, HF = 1, HS = 2, HB = 1;
   localparam int   VA = 3, VF = 1, VS = 1, VB = 1;
   localparam int   HT = HA + HF + HS + HB;
   localparam int   VT = VA + VF + VS + VB;
   localparam int   FRAME = HT * VT;
   localparam int   CW = 4;
   localparam logic POL = 1'b1;
   localparam int   VW = 9 + 2 * CW;

   logic          clk = 1'b1;
   logic          reset = 1'b1;
   logic          enable = 1'b0;
   logic          pixel_ce, hsync, vsync, hblank, vblank, de, line_start, frame_start, running;
   logic [CW-1:0] h_count, v_count;

   vga_timing_gen #(
      .CE_DIV(CE), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HS_POL(POL), .VS_POL(POL), .CNT_W(CW)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .pixel_ce(pixel_ce),
      .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank), .de(de),
      .h_count(h_count), .v_count(v_count), .line_start(line_start),
      .frame_start(frame_start), .running(running)
   );

   always #5 clk = ~clk;

   // Reference model: free-running divider phase, running flag and linear pixel index within the frame.
   int  m_div = 0;
   bit  m_pce = 0, m_run = 0, m_ls = 0, m_fs = 0;
   int  m_p = 0;

   logic [VW-1:0] sb[$];
   int  n_chk = 0, n_pass = 0, n_fail = 0;

   function automatic logic [VW-1:0] expected();
      int h, v;
      logic hs, vs, hb, vb;
      h  = m_run ? m_p % HT : 0;
      v  = m_run ? m_p / HT : 0;
      hs = (m_run && h >= HA + HF && h < HA + HF + HS) ? POL : ~POL;
      vs = (m_run && v >= VA + VF && v < VA + VF + VS) ? POL : ~POL;
      hb = !m_run || h >= HA;
      vb = !m_run || v >= VA;
      return {m_pce, hs, vs, hb, vb, !hb && !vb, CW'(h), CW'(v), m_ls, m_fs, m_run};
   endfunction

   task automatic model_edge(input bit rst, input bit en);
      bit ce;
      if (rst) begin
         m_div = 0; m_pce = 0; m_run = 0; m_p = 0; m_ls = 0; m_fs = 0;
      end else begin
         ce    = m_pce;
         m_div = (m_div + 1) % CE;
         m_pce = (m_div == CE - 1);
         m_ls  = 0;
         m_fs  = 0;
         if (ce) begin
            if (!m_run) begin
               if (en) begin
                  m_run = 1; m_p = 0; m_ls = 1; m_fs = 1;
               end
            end else if (!en && m_p == FRAME - 1) begin
               m_run = 0; m_p = 0;
            end else begin
               m_p  = (m_p + 1) % FRAME;
               m_ls = (m_p % HT == 0);
               m_fs = (m_p == 0);
            end
         end
      end
   endtask

   task automatic step(input bit rst, input bit en);
      @(negedge clk);
      reset  = rst;
      enable = en;
      model_edge(rst, en);
      sb.push_back(expected());
   endtask

   // Monitor: every clock the DUT presents a full output vector; compare against the queued expectation.
   initial begin
      logic [VW-1:0] exp_v, act_v;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            exp_v = sb.pop_front();
            act_v = {pixel_ce, hsync, vsync, hblank, vblank, de, h_count, v_count,
                     line_start, frame_start, running};
            n_chk++;
            if (act_v === exp_v) n_pass++;
            else begin
               n_fail++;
               if (n_fail <= 20)
                  $display("FAIL outputs t=%0t actual{ce,hs,vs,hb,vb,de,h,v,ls,fs,run}=%b required=%b",
                           $time, act_v, exp_v);
            end
         end
      end
   end

   initial begin
      int guard;
      bit en;
      // Reset held three clocks, then enable and run several frames.
      repeat (3) step(1, 0);
      repeat (FRAME * CE * 3 + 20) step(0, 1);

      // Stop: drop enable mid-frame and let the frame drain to idle.
      guard = 0;
      while (!(m_run && m_p == 2 * HT) && guard < 1000) begin step(0, 1); guard++; end
      repeat (FRAME * CE + 30) step(0, 0);

      // Resume: drop then re-raise enable within one frame.
      repeat (FRAME * CE) step(0, 1);
      repeat (HT * CE) step(0, 0);
      repeat (FRAME * CE * 2) step(0, 1);

      // Enable falls exactly on the pixel_ce of the last pixel of a frame.
      guard = 0;
      while (!(m_run && m_pce && m_p == FRAME - 1) && guard < 1000) begin step(0, 1); guard++; end
      repeat (2 * CE + 5) step(0, 0);
      repeat (20) step(0, 1);

      // Reset mid-frame.
      guard = 0;
      while (!(m_run && m_p == 3 * HT + 2) && guard < 1000) begin step(0, 1); guard++; end
      step(1, 1);
      repeat (FRAME * CE) step(0, 1);

      // Randomised enable toggling with occasional resets.
      en = 1;
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 99) < 3) en = ~en;
         step($urandom_range(0, 999) < 2, en);
      end

      guard = 0;
      while (sb.size() > 0 && guard < 20) begin @(negedge clk); guard++; end
      if (sb.size() > 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain actual=%0d pending required=0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
